// File: rtl/ulpi_pkg.sv
// Shared constants for the ULPI register controller: PHY register map,
// start-up configuration table and controller state encoding.
package ulpi_pkg;

    localparam logic [5:0] FUNC_CTRL      = 6'h04;
    localparam logic [5:0] OTG_CTRL       = 6'h0A;

    // SuspendM, non-driving op mode, full-speed transceiver
    localparam logic [7:0] FUNC_CTRL_INIT = 8'h49;
    // D+/D- pull-downs off so the sniffer stays passive
    localparam logic [7:0] OTG_CTRL_INIT  = 8'h00;

    localparam int INIT_LEN = 2;

    localparam logic [2:0] ST_WAIT_PHY   = 3'd0;
    localparam logic [2:0] ST_INIT_ISSUE = 3'd1;
    localparam logic [2:0] ST_INIT_WAIT  = 3'd2;
    localparam logic [2:0] ST_IDLE       = 3'd3;
    localparam logic [2:0] ST_ISSUE      = 3'd4;
    localparam logic [2:0] ST_WAIT       = 3'd5;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] val;
    } init_entry_t;

    function automatic init_entry_t init_entry(input logic [1:0] idx);
        init_entry_t e;
        case (idx)
            2'd0: begin
                e.addr = FUNC_CTRL;
                e.val  = FUNC_CTRL_INIT;
            end
            default: begin
                e.addr = OTG_CTRL;
                e.val  = OTG_CTRL_INIT;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ulpi_rr_arb2.sv
// Two-way round-robin arbiter; the requester whose access was just
// acknowledged drops to lower priority.
module ulpi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] ack,
    output logic [1:0] gnt
);

    logic r_prio;

    always_comb begin
        gnt = 2'b00;
        if (!r_prio) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (ack[0]) begin
            r_prio <= 1'b1;
        end else if (ack[1]) begin
            r_prio <= 1'b0;
        end
    end

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI register access sequencer: PHY start-up wait, configuration table
// write-out, then arbitrated read/write service with abort retry.
module ulpi_reg_ctrl
    import ulpi_pkg::*;
#(
    parameter int STARTUP_CYCLES = 600,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk_ULPI,
    input  logic        rst,
    input  logic        DIR,
    input  logic [1:0]  req,
    input  logic [1:0]  rw,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    output logic [1:0]  ack,
    output logic [1:0]  err,
    output logic [7:0]  rdata,
    output logic        init_done,
    output logic        init_fail,
    output logic        PrW,
    output logic        PrR,
    output logic [5:0]  ADDR,
    output logic [7:0]  REG_VAL,
    input  logic        wr_busy,
    input  logic        wr_abort,
    input  logic        rd_busy,
    input  logic        rd_abort,
    input  logic [7:0]  RD_VAL
);

    localparam int              CNT_W       = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [1:0]      RETRY_LIMIT = 2'(MAX_RETRY);
    localparam logic [1:0]      INIT_LAST   = 2'(INIT_LEN - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_init_idx;
    logic [1:0]       r_retry;
    logic             r_is_wr;
    logic             r_gnt;
    logic             r_busy_prev;
    logic             r_prw;
    logic             r_prr;
    logic [5:0]       r_addr;
    logic [7:0]       r_regval;
    logic [1:0]       r_ack;
    logic [1:0]       r_err;
    logic [7:0]       r_rdata;
    logic             r_init_done;
    logic             r_init_fail;

    logic [5:0]  w_req_addr  [2];
    logic [7:0]  w_req_wdata [2];
    logic [1:0]  w_req_eff;
    logic [1:0]  w_gnt;
    logic        w_gnt_idx;
    logic [1:0]  w_gnt_onehot;
    logic [1:0]  w_ack_next;
    logic        w_busy;
    logic        w_abort;
    logic        w_fall;
    logic        w_retry_max;
    logic [1:0]  w_retry_inc;
    logic        w_launch;
    logic        w_init_step;
    logic        w_user_done;
    logic        w_user_fail;
    init_entry_t w_init_first;
    init_entry_t w_init_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_req_addr[gi]  = addr[gi*6 +: 6];
            assign w_req_wdata[gi] = wdata[gi*8 +: 8];
        end
    endgenerate

    // A requester still sees its own ack this cycle; mask it so it is not re-granted
    assign w_req_eff = req & ~r_ack;

    ulpi_rr_arb2 u_arb (
        .clk (clk_ULPI),
        .rst (rst),
        .req (w_req_eff),
        .ack (w_ack_next),
        .gnt (w_gnt)
    );

    assign w_gnt_idx    = w_gnt[1];
    assign w_gnt_onehot = r_gnt ? 2'b10 : 2'b01;

    assign w_busy      = r_is_wr ? wr_busy  : rd_busy;
    assign w_abort     = r_is_wr ? wr_abort : rd_abort;
    assign w_fall      = r_busy_prev & ~w_busy;
    assign w_retry_max = (r_retry == RETRY_LIMIT);
    assign w_retry_inc = (r_retry == 2'b11) ? r_retry : r_retry + 2'd1;

    assign w_launch = ((r_state == ST_INIT_ISSUE) || (r_state == ST_ISSUE)) && !DIR && !w_busy;

    // An abort takes precedence over a busy fall in the same cycle
    assign w_init_step = (r_state == ST_INIT_WAIT) && (w_abort ? w_retry_max : w_fall);
    assign w_user_done = (r_state == ST_WAIT) && !w_abort && w_fall;
    assign w_user_fail = (r_state == ST_WAIT) && w_abort && w_retry_max;
    assign w_ack_next  = (w_user_done || w_user_fail) ? w_gnt_onehot : 2'b00;

    assign w_init_first = init_entry(2'd0);
    assign w_init_next  = init_entry(r_init_idx + 2'd1);

    always_ff @(posedge clk_ULPI) begin
        if (!rst) begin
            r_state     <= ST_WAIT_PHY;
            r_cnt       <= '0;
            r_init_idx  <= '0;
            r_retry     <= '0;
            r_is_wr     <= 1'b0;
            r_gnt       <= 1'b0;
            r_busy_prev <= 1'b0;
            r_prw       <= 1'b0;
            r_prr       <= 1'b0;
            r_addr      <= '0;
            r_regval    <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_init_done <= 1'b0;
            r_init_fail <= 1'b0;
        end else begin
            r_prw       <= 1'b0;
            r_prr       <= 1'b0;
            r_ack       <= w_ack_next;
            r_err       <= w_user_fail ? w_gnt_onehot : 2'b00;
            r_busy_prev <= w_busy;

            case (r_state)
                ST_WAIT_PHY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= ST_INIT_ISSUE;
                        r_init_idx <= '0;
                        r_addr     <= w_init_first.addr;
                        r_regval   <= w_init_first.val;
                        r_retry    <= '0;
                        r_is_wr    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_INIT_ISSUE: begin
                    if (w_launch) begin
                        r_prw   <= 1'b1;
                        r_state <= ST_INIT_WAIT;
                    end
                end

                ST_INIT_WAIT: begin
                    if (w_init_step) begin
                        if (w_abort) begin
                            r_init_fail <= 1'b1;
                        end
                        if (r_init_idx == INIT_LAST) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_addr     <= w_init_next.addr;
                            r_regval   <= w_init_next.val;
                            r_retry    <= '0;
                            r_state    <= ST_INIT_ISSUE;
                        end
                    end else if (w_abort) begin
                        r_retry <= w_retry_inc;
                        r_state <= ST_INIT_ISSUE;
                    end
                end

                ST_IDLE: begin
                    if (|w_req_eff) begin
                        r_gnt    <= w_gnt_idx;
                        r_is_wr  <= rw[w_gnt_idx];
                        r_addr   <= w_req_addr[w_gnt_idx];
                        r_regval <= w_req_wdata[w_gnt_idx];
                        r_retry  <= '0;
                        r_state  <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (w_launch) begin
                        r_prw   <= r_is_wr;
                        r_prr   <= !r_is_wr;
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (w_abort) begin
                        if (w_retry_max) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_retry <= w_retry_inc;
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_fall) begin
                        if (!r_is_wr) begin
                            r_rdata <= RD_VAL;
                        end
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_WAIT_PHY;
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign init_done = r_init_done;
    assign init_fail = r_init_fail;
    assign PrW       = r_prw;
    assign PrR       = r_prr;
    assign ADDR      = r_addr;
    assign REG_VAL   = r_regval;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl with a behavioural model of the ULPI
// register read/write engines and an abort injector.
module tb_ulpi_reg_ctrl;

    logic        clk_ULPI = 1'b0;
    logic        rst      = 1'b0;
    logic        DIR      = 1'b0;
    logic [1:0]  req      = 2'b00;
    logic [1:0]  rw       = 2'b00;
    logic [11:0] addr     = '0;
    logic [15:0] wdata    = '0;
    logic        wr_busy  = 1'b0;
    logic        wr_abort = 1'b0;
    logic        rd_busy  = 1'b0;
    logic        rd_abort = 1'b0;
    logic [7:0]  RD_VAL   = 8'h00;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic        init_done;
    logic        init_fail;
    logic        PrW;
    logic        PrR;
    logic [5:0]  ADDR;
    logic [7:0]  REG_VAL;

    int n_cmp = 0;
    int n_bad = 0;
    int overlap = 0;
    int abort_left = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    typedef struct {
        bit         is_wr;
        logic [5:0] a;
        logic [7:0] v;
    } launch_t;
    launch_t lq[$];

    ulpi_reg_ctrl dut (
        .clk_ULPI  (clk_ULPI),
        .rst       (rst),
        .DIR       (DIR),
        .req       (req),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .init_done (init_done),
        .init_fail (init_fail),
        .PrW       (PrW),
        .PrR       (PrR),
        .ADDR      (ADDR),
        .REG_VAL   (REG_VAL),
        .wr_busy   (wr_busy),
        .wr_abort  (wr_abort),
        .rd_busy   (rd_busy),
        .rd_abort  (rd_abort),
        .RD_VAL    (RD_VAL)
    );

    always #5 clk_ULPI = ~clk_ULPI;

    // Engine model: busy for 3 cycles after a start pulse, optional abort at the end
    always @(negedge clk_ULPI) begin
        launch_t l;
        wr_abort = 1'b0;
        rd_abort = 1'b0;
        if ((PrW || PrR) && (wr_busy || rd_busy || (PrW && PrR))) overlap++;
        if (PrW) begin
            l.is_wr = 1'b1; l.a = ADDR; l.v = REG_VAL;
            lq.push_back(l);
            wr_busy = 1'b1; wr_cnt = 3;
        end else if (wr_busy) begin
            wr_cnt--;
            if (wr_cnt == 0) begin
                wr_busy = 1'b0;
                if (abort_left > 0) begin
                    wr_abort = 1'b1;
                    abort_left--;
                end
            end
        end
        if (PrR) begin
            l.is_wr = 1'b0; l.a = ADDR; l.v = 8'h00;
            lq.push_back(l);
            rd_busy = 1'b1; rd_cnt = 3;
        end else if (rd_busy) begin
            rd_cnt--;
            if (rd_cnt == 0) rd_busy = 1'b0;
        end
    end

    task automatic run_access(input int idx, input bit wr, input logic [5:0] a, input logic [7:0] d,
                              output bit got, output logic e, output int lat);
        got = 1'b0; e = 1'b0; lat = -1;
        rw[idx] = wr;
        addr[idx*6 +: 6] = a;
        wdata[idx*8 +: 8] = d;
        req[idx] = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk_ULPI);
            if (lat < 0 && (PrW || PrR)) lat = c;
            if (ack[idx]) begin
                got = 1'b1;
                e = err[idx];
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk_ULPI);
        n_cmp++; if (PrW !== 1'b0)       begin n_bad++; $display("FAIL reset_PrW: got %0h want 0", PrW); end
        n_cmp++; if (PrR !== 1'b0)       begin n_bad++; $display("FAIL reset_PrR: got %0h want 0", PrR); end
        n_cmp++; if (ack !== 2'b00)      begin n_bad++; $display("FAIL reset_ack: got %0h want 0", ack); end
        n_cmp++; if (err !== 2'b00)      begin n_bad++; $display("FAIL reset_err: got %0h want 0", err); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %0h want 0", init_done); end
        n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL reset_init_fail: got %0h want 0", init_fail); end
        n_cmp++; if (ADDR !== 6'h00)     begin n_bad++; $display("FAIL reset_ADDR: got %0h want 0", ADDR); end
        n_cmp++; if (REG_VAL !== 8'h00)  begin n_bad++; $display("FAIL reset_REG_VAL: got %0h want 0", REG_VAL); end
        n_cmp++; if (rdata !== 8'h00)    begin n_bad++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
        $display("reset: outputs checked, releasing rst");
        lq.delete();
        rst = 1'b1;
    endtask

    task automatic test_init();
        int first = -1;
        for (int c = 1; c <= 1000 && !init_done; c++) begin
            @(negedge clk_ULPI);
            if (first < 0 && PrW) first = c;
        end
        $display("init: first PrW at cycle %0d, %0d launches, init_done=%0b", first, lq.size(), init_done);
        n_cmp++; if (first != 601)       begin n_bad++; $display("FAIL init_first_launch: got %0d want 601", first); end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done: got %0h want 1", init_done); end
        n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL init_fail: got %0h want 0", init_fail); end
        n_cmp++; if (lq.size() != 2)     begin n_bad++; $display("FAIL init_count: got %0d want 2", lq.size()); end
        if (lq.size() >= 2) begin
            n_cmp++; if (lq[0].a !== 6'h04 || lq[0].v !== 8'h49)
                begin n_bad++; $display("FAIL init_entry0: got %0h/%0h want 04/49", lq[0].a, lq[0].v); end
            n_cmp++; if (lq[1].a !== 6'h0A || lq[1].v !== 8'h00)
                begin n_bad++; $display("FAIL init_entry1: got %0h/%0h want 0a/00", lq[1].a, lq[1].v); end
        end
    endtask

    task automatic test_write();
        bit got; logic e; int lat; int n0;
        repeat (3) @(negedge clk_ULPI);
        n0 = lq.size();
        run_access(0, 1'b1, 6'h16, 8'hAF, got, e, lat);
        $display("write req0 16<-af: ack=%0b err=%0b latency=%0d", got, e, lat);
        n_cmp++; if (got !== 1'b1)          begin n_bad++; $display("FAIL wr_ack: got %0h want 1", got); end
        n_cmp++; if (e !== 1'b0)            begin n_bad++; $display("FAIL wr_err: got %0h want 0", e); end
        n_cmp++; if (lat != 2)              begin n_bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_cmp++; if (lq.size() != n0 + 1)   begin n_bad++; $display("FAIL wr_count: got %0d want %0d", lq.size(), n0 + 1); end
        if (lq.size() > n0) begin
            n_cmp++; if (lq[n0].is_wr !== 1'b1 || lq[n0].a !== 6'h16 || lq[n0].v !== 8'hAF)
                begin n_bad++; $display("FAIL wr_launch: got w%0b %0h/%0h want w1 16/af", lq[n0].is_wr, lq[n0].a, lq[n0].v); end
        end
    endtask

    task automatic test_read();
        bit got; logic e; int lat; int n0;
        repeat (2) @(negedge clk_ULPI);
        RD_VAL = 8'hBA;
        n0 = lq.size();
        run_access(1, 1'b0, 6'h2F, 8'h00, got, e, lat);
        $display("read req1 2f: ack=%0b err=%0b rdata=%0h", got, e, rdata);
        n_cmp++; if (got !== 1'b1)     begin n_bad++; $display("FAIL rd_ack: got %0h want 1", got); end
        n_cmp++; if (e !== 1'b0)       begin n_bad++; $display("FAIL rd_err: got %0h want 0", e); end
        n_cmp++; if (rdata !== 8'hBA)  begin n_bad++; $display("FAIL rd_data: got %0h want ba", rdata); end
        if (lq.size() > n0) begin
            n_cmp++; if (lq[n0].is_wr !== 1'b0 || lq[n0].a !== 6'h2F)
                begin n_bad++; $display("FAIL rd_launch: got w%0b %0h want w0 2f", lq[n0].is_wr, lq[n0].a); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL rd_launch: got none want one PrR");
        end
        RD_VAL = 8'h00;
        repeat (3) @(negedge clk_ULPI);
        n_cmp++; if (rdata !== 8'hBA)  begin n_bad++; $display("FAIL rd_hold: got %0h want ba", rdata); end
    endtask

    task automatic test_back_to_back();
        int order[$];
        int n0;
        bit seen0, seen1;
        n0 = lq.size();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk_ULPI);
            rw = 2'b11;
            addr = {6'h33, 6'h11};
            wdata = {8'h44, 8'h22};
            req = 2'b11;
            seen0 = 1'b0; seen1 = 1'b0;
            for (int c = 0; c < 300 && !(seen0 && seen1); c++) begin
                @(negedge clk_ULPI);
                if (ack[0]) begin order.push_back(0); req[0] = 1'b0; seen0 = 1'b1; end
                if (ack[1]) begin order.push_back(1); req[1] = 1'b0; seen1 = 1'b1; end
            end
        end
        req = 2'b00;
        $display("back_to_back: %0d acks, %0d launches, overlap=%0d", order.size(), lq.size() - n0, overlap);
        n_cmp++; if (order.size() != 4) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 4", order.size()); end
        if (order.size() == 4) begin
            n_cmp++; if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1)
                begin n_bad++; $display("FAIL b2b_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]); end
        end
        if (lq.size() >= n0 + 4) begin
            n_cmp++; if (lq[n0].a !== 6'h11 || lq[n0+1].a !== 6'h33 || lq[n0+2].a !== 6'h11 || lq[n0+3].a !== 6'h33)
                begin n_bad++; $display("FAIL b2b_addrs: got %0h %0h %0h %0h want 11 33 11 33",
                                        lq[n0].a, lq[n0+1].a, lq[n0+2].a, lq[n0+3].a); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL b2b_addrs: got %0d launches want 4", lq.size() - n0);
        end
        n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_dir_abort();
        int blocked = 0;
        int n0;
        bit got = 1'b0;
        logic e = 1'b0;
        @(negedge clk_ULPI);
        DIR = 1'b1;
        rw[0] = 1'b1; addr[5:0] = 6'h05; wdata[7:0] = 8'h5A; req[0] = 1'b1;
        repeat (20) begin
            @(negedge clk_ULPI);
            if (PrW || PrR) blocked++;
        end
        n_cmp++; if (blocked != 0) begin n_bad++; $display("FAIL dir_block: got %0d launches want 0", blocked); end
        n0 = lq.size();
        abort_left = 4;
        DIR = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk_ULPI);
            if (ack[0]) begin got = 1'b1; e = err[0]; end
        end
        req[0] = 1'b0;
        $display("dir_abort: blocked=%0d launches=%0d ack=%0b err=%0b", blocked, lq.size() - n0, got, e);
        n_cmp++; if (got !== 1'b1)          begin n_bad++; $display("FAIL abort_ack: got %0h want 1", got); end
        n_cmp++; if (e !== 1'b1)            begin n_bad++; $display("FAIL abort_err: got %0h want 1", e); end
        n_cmp++; if (lq.size() - n0 != 4)   begin n_bad++; $display("FAIL abort_launches: got %0d want 4", lq.size() - n0); end
        n_cmp++; if (abort_left != 0)       begin n_bad++; $display("FAIL abort_used: got %0d left want 0", abort_left); end
        abort_left = 0;
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        bit launched = 1'b0;
        logic e = 1'b0;
        int n0;
        repeat (2) @(negedge clk_ULPI);
        rw[0] = 1'b1; addr[5:0] = 6'h2C; wdata[7:0] = 8'hA1; req[0] = 1'b1;
        for (int c = 0; c < 20 && !launched; c++) begin
            @(negedge clk_ULPI);
            if (PrW) launched = 1'b1;
        end
        @(negedge clk_ULPI);
        rst = 1'b0;
        @(negedge clk_ULPI);
        n_cmp++; if (launched !== 1'b1) begin n_bad++; $display("FAIL mid_launch: got %0h want 1", launched); end
        n_cmp++; if ({PrW, PrR, ack, err} !== 6'b0) begin n_bad++; $display("FAIL mid_ctrl: got %0h want 0", {PrW, PrR, ack, err}); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL mid_init_done: got %0h want 0", init_done); end
        n_cmp++; if ({ADDR, REG_VAL, rdata} !== 22'h0) begin n_bad++; $display("FAIL mid_data: got %0h want 0", {ADDR, REG_VAL, rdata}); end
        rst = 1'b1;
        n0 = lq.size();
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk_ULPI);
            if (ack[0]) begin got = 1'b1; e = err[0]; end
        end
        req[0] = 1'b0;
        $display("reset_mid: launches after reset=%0d ack=%0b err=%0b init_done=%0b", lq.size() - n0, got, e, init_done);
        n_cmp++; if (got !== 1'b1 || e !== 1'b0) begin n_bad++; $display("FAIL mid_ack: got ack%0b err%0b want ack1 err0", got, e); end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL mid_reinit: got %0h want 1", init_done); end
        n_cmp++; if (lq.size() - n0 != 3) begin n_bad++; $display("FAIL mid_count: got %0d want 3", lq.size() - n0); end
        if (lq.size() >= n0 + 3) begin
            n_cmp++; if (lq[n0].a !== 6'h04 || lq[n0].v !== 8'h49 || lq[n0+1].a !== 6'h0A || lq[n0+1].v !== 8'h00)
                begin n_bad++; $display("FAIL mid_init_seq: got %0h/%0h %0h/%0h want 04/49 0a/00",
                                        lq[n0].a, lq[n0].v, lq[n0+1].a, lq[n0+1].v); end
            n_cmp++; if (lq[n0+2].a !== 6'h2C || lq[n0+2].v !== 8'hA1)
                begin n_bad++; $display("FAIL mid_pending: got %0h/%0h want 2c/a1", lq[n0+2].a, lq[n0+2].v); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_read();
        test_back_to_back();
        test_dir_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
